// File: rtl/fused_cnn_pkg.sv
// Shared types and defaults for the fused CNN datapath blocks.
// Holds SRAM geometry defaults, the fetch state encoding and tile-length helpers.
package fused_cnn_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  localparam int TILE_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // A zero-length tile still carries one word.
  function automatic logic [TILE_LEN_W-1:0] eff_tile_len(input logic [TILE_LEN_W-1:0] len);
    return (len == '0) ? TILE_LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/ifm_fetch_if.sv
// Bundle of the fetch block's controller, SRAM and PE-side signals.
// slave is the fetch block itself; master is whatever surrounds it.
interface ifm_fetch_if
  import fused_cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  en;
  logic [ADDR_W-1:0]     addr;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [TILE_LEN_W-1:0] tile_len;
  logic                  mem_re;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     pe_data;
  logic                  pe_valid;
  logic                  pe_ready;
  logic                  pe_last;
  logic                  busy;

  modport slave (
    input  en, addr, addr_valid, tile_len, mem_rdata, pe_ready,
    output addr_ready, mem_re, mem_addr, pe_data, pe_valid, pe_last, busy
  );

  modport master (
    output en, addr, addr_valid, tile_len, mem_rdata, pe_ready,
    input  addr_ready, mem_re, mem_addr, pe_data, pe_valid, pe_last, busy
  );

endinterface

// File: rtl/ifm_fetch_sync_fifo.sv
// Small single-clock FIFO with occupancy output; head word is visible combinationally.
// The caller never pushes into a full FIFO nor pops an empty one.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define
  // validity, so stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ifm_fetch.sv
// Input feature-map fetch: issues SRAM reads for controller addresses and
// streams the returned words to the PE through a small FIFO, marking tile ends.
module ifm_fetch
  import fused_cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input logic        clk,
  input logic        reset,
  ifm_fetch_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t          state;
  logic                  inflight;
  logic [TILE_LEN_W-1:0] tile_len_q;
  logic [TILE_LEN_W-1:0] acc_cnt;
  logic [TILE_LEN_W-1:0] pop_cnt;
  logic [CNT_W-1:0]      occupancy;
  logic [DATA_W-1:0]     head_data;
  logic                  room;
  logic                  accept;
  logic                  pop;

  // Read in flight reserves a slot, so returning data always has somewhere to land.
  assign room = ({1'b0, occupancy} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH);

  assign bus.addr_ready = bus.en & ~reset & (state != DRAIN) & room;
  assign accept         = bus.addr_valid & bus.addr_ready;
  assign bus.mem_re     = accept;
  assign bus.mem_addr   = accept ? bus.addr : '0;

  assign bus.pe_valid = (occupancy != '0);
  assign bus.pe_data  = bus.pe_valid ? head_data : '0;
  assign bus.pe_last  = bus.pe_valid & (pop_cnt == tile_len_q - TILE_LEN_W'(1));
  assign pop          = bus.pe_valid & bus.pe_ready;

  assign bus.busy = (state != IDLE) | inflight | (occupancy != '0);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.mem_rdata),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (occupancy)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      tile_len_q <= '0;
      acc_cnt    <= '0;
      pop_cnt    <= '0;
    end else begin
      inflight <= accept;

      if (pop) pop_cnt <= bus.pe_last ? '0 : pop_cnt + TILE_LEN_W'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            tile_len_q <= eff_tile_len(bus.tile_len);
            acc_cnt    <= TILE_LEN_W'(1);
            state      <= (eff_tile_len(bus.tile_len) == TILE_LEN_W'(1)) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + TILE_LEN_W'(1);
            if (acc_cnt + TILE_LEN_W'(1) == tile_len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && bus.pe_last) begin
            acc_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_fetch.sv
// Directed bench for ifm_fetch: SRAM model returns {12'hC0D, addr} one cycle after mem_re.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_ifm_fetch;

  logic clk;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  ifm_fetch_if bus ();

  ifm_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outside a read-return cycle the SRAM bus carries garbage.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_re ? {12'hC0D, bus.mem_addr} : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Runs one tile: offers n_offer consecutive addresses from base, expects n_words
  // delivered in order with pe_last only on the final one.
  task automatic run_tile(input string name, input int len, input logic [19:0] base,
                          input int n_words, input int n_offer, input int hold,
                          input bit toggle, input int gap_after, input int gap_len);
    int          cyc = 0, issued = 0, popped = 0, lasts = 0;
    int          first_acc = -1, first_vld = -1;
    int          gap_left = 0, gap_re = 0;
    bit          gap_done = 0, prev_stall = 0, is_acc;
    logic [31:0] prev_data, exp_w;
    logic        prev_last;
    logic [31:0] expq[$];

    bus.tile_len = 16'(len);
    while (popped < n_words && cyc < 400) begin
      bus.en         = (gap_left == 0);
      bus.addr_valid = (issued < n_offer);
      bus.addr       = base + 20'(issued);
      bus.pe_ready   = (cyc >= hold) && (!toggle || (cyc % 2 == 0));
      #1;
      is_acc = bus.addr_valid & bus.addr_ready;
      check({name, " mem_re"}, 32'(bus.mem_re), 32'(is_acc));

      if (prev_stall) begin
        check({name, " hold valid"}, 32'(bus.pe_valid), 32'd1);
        check({name, " hold data"}, bus.pe_data, prev_data);
        check({name, " hold last"}, 32'(bus.pe_last), 32'(prev_last));
      end
      if (bus.pe_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (bus.pe_ready) begin
          exp_w = (expq.size() > 0) ? expq.pop_front() : 32'hBAD0_0000;
          check({name, " data"}, bus.pe_data, exp_w);
          check({name, " last"}, 32'(bus.pe_last), 32'(popped == n_words - 1));
          if (bus.pe_last) lasts++;
          popped++;
        end
      end
      prev_stall = bus.pe_valid & ~bus.pe_ready;
      prev_data  = bus.pe_data;
      prev_last  = bus.pe_last;

      if (gap_left > 0) begin
        if (bus.mem_re) gap_re++;
        gap_left--;
        if (gap_left == 0) begin
          check({name, " gap mem_re"}, 32'(gap_re), 32'd0);
          check({name, " gap pops"}, 32'(popped), 32'(gap_after));
        end
      end

      if (is_acc) begin
        if (first_acc < 0) first_acc = cyc;
        check({name, " mem_addr"}, 32'(bus.mem_addr), 32'(bus.addr));
        expq.push_back({12'hC0D, bus.addr});
        issued++;
        if (gap_after > 0 && issued == gap_after && !gap_done) begin
          gap_left = gap_len;
          gap_done = 1'b1;
        end
      end

      if (hold > 0 && cyc == hold - 1) begin
        check({name, " stall accepts"}, 32'(issued), 32'd4);
        check({name, " stall ready"}, 32'(bus.addr_ready), 32'd0);
      end

      @(posedge clk); #1;
      cyc++;
    end

    check({name, " words"}, 32'(popped), 32'(n_words));
    check({name, " accepts"}, 32'(issued), 32'(n_words));
    check({name, " lasts"}, 32'(lasts), 32'd1);
    check({name, " latency"}, 32'(first_vld - first_acc), 32'd2);

    bus.addr_valid = 1'b0;
    bus.pe_ready   = 1'b0;
    bus.en         = 1'b1;
    #1;
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
    check({name, " idle valid"}, 32'(bus.pe_valid), 32'd0);
    check({name, " idle ready"}, 32'(bus.addr_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.en         = 1'b1;
    bus.addr       = '0;
    bus.addr_valid = 1'b1;
    bus.pe_ready   = 1'b1;
    bus.tile_len   = 16'd8;

    @(posedge clk); #1;
    #1;
    check("reset addr_ready", 32'(bus.addr_ready), 32'd0);
    check("reset mem_re", 32'(bus.mem_re), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.addr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post-reset pe_valid", 32'(bus.pe_valid), 32'd0);
    check("post-reset pe_last", 32'(bus.pe_last), 32'd0);
    check("post-reset pe_data", bus.pe_data, 32'd0);
    check("post-reset busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    //        name       len base       words offer hold tog gap_after gap_len
    run_tile("burst8",   8,  20'h00010, 8,    8,    0,   0,  0,        0);
    run_tile("stall6",   6,  20'h00100, 6,    6,    10,  0,  0,        0);
    run_tile("toggle16", 16, 20'h00200, 16,   20,   0,   1,  0,        0);
    run_tile("engap5",   5,  20'h00280, 5,    5,    0,   0,  3,        5);

    // Reset with two words buffered and a third read in flight.
    bus.tile_len   = 16'd4;
    bus.pe_ready   = 1'b0;
    bus.addr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.addr = 20'h00300 + 20'(i);
      #1;
      check("rst pre accept", 32'(bus.addr_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.addr_valid = 1'b0;
    reset          = 1'b1;
    #1;
    check("rst buffered valid", 32'(bus.pe_valid), 32'd1);
    check("rst ready gated", 32'(bus.addr_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst flush valid", 32'(bus.pe_valid), 32'd0);
    check("rst flush busy", 32'(bus.busy), 32'd0);
    check("rst flush data", bus.pe_data, 32'd0);
    @(posedge clk); #1;
    #1;
    check("rst stale valid", 32'(bus.pe_valid), 32'd0);
    check("rst stale busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    run_tile("after_rst2", 2, 20'h00400, 2, 2, 0, 0, 0, 0);
    run_tile("len0",       0, 20'h00500, 1, 3, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ifm_fetch.md
IFM_FETCH -- requirements
Module: ifm_fetch

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word address width.
REQ-002 Parameter DATA_W, default 32, SRAM word width (4 x int8 activations).
REQ-003 Parameter DEPTH, default 4, output buffer entries (power of two, >= 2).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  block enable; when low, no new reads issue and held output stays stable.
REQ-007 addr  in  ADDR_W  read address from Controller_PE.
REQ-008 addr_valid  in  1  addr is valid this cycle.
REQ-009 addr_ready  out  1  fetch accepts addr this cycle.
REQ-010 tile_len  in  16  words per tile, sampled at tile start; 0 treated as 1.
REQ-011 mem_re  out  1  SRAM read enable.
REQ-012 mem_addr  out  ADDR_W  SRAM read address.
REQ-013 mem_rdata  in  DATA_W  SRAM data, valid exactly 1 cycle after mem_re.
REQ-014 pe_data  out  DATA_W  activation word to PE.
REQ-015 pe_valid  out  1  pe_data valid.
REQ-016 pe_ready  in  1  PE consumes word.
REQ-017 pe_last  out  1  marks final word of current tile.
REQ-018 busy  out  1  reads in flight or buffer non-empty.

Function
REQ-019 Address accept = addr_valid & addr_ready; on accept, mem_re=1 and mem_addr=addr combinationally the same cycle.
REQ-020 addr_ready = en & (occupancy + inflight < DEPTH); inflight is 0 or 1 (1-cycle read latency).
REQ-021 mem_rdata SHALL be written to buffer on the cycle after mem_re; no read data is ever dropped.
REQ-022 Buffer is FIFO-ordered; pe_data/pe_valid driven from head, first-word latency = 2 cycles from accept to pe_valid.
REQ-023 Pop = pe_valid & pe_ready; simultaneous push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 pe_data and pe_last SHALL hold stable while pe_valid & !pe_ready.
REQ-025 Sustained throughput: 1 word/cycle when addr_valid and pe_ready both held high.
REQ-026 Word counter counts pops from 0; pe_last = pe_valid & (count == tile_len_q - 1); on popping the last word counter wraps to 0 and tile_len is resampled.
REQ-027 tile_len_q captured on first accept when counter == 0 and no tile active; changes to tile_len mid-tile are ignored.
REQ-028 State machine IDLE -> RUN on first accept; RUN -> DRAIN when accepted words == tile_len_q; DRAIN -> IDLE when last word popped; in DRAIN addr_ready = 0.
REQ-029 en low mid-tile: stops new accepts only; in-flight read still lands; buffered words still deliverable.
REQ-030 busy = (state != IDLE) | inflight | (occupancy != 0).

Reset
REQ-031 On reset: pe_valid=0, pe_last=0, pe_data=0, mem_re=0, mem_addr=0, addr_ready=0 for that cycle, busy=0, occupancy=0, inflight=0, counters=0, state=IDLE.
REQ-032 Reset mid-operation SHALL discard buffered and in-flight data; mem_rdata arriving the cycle after reset is ignored.

Structure
REQ-033 ADDR_W, DATA_W defaults and the state enum (IDLE, RUN, DRAIN) SHALL live in shared package fused_cnn_pkg.
REQ-034 Buffer SHALL be a sub-module sync_fifo (DEPTH, DATA_W+1 wide carrying last flag or computed at head), synchronous reset.

Verification
REQ-035 tile_len=8, addr 0x00010..0x00017 back-to-back, pe_ready=1 -> 8 words in order, pe_valid first 2 cycles after first accept, pe_last only on 8th, then IDLE, busy=0.
REQ-036 tile_len=6, pe_ready=0 for 10 cycles -> addr_ready drops after 4 accepts, occupancy 4, no word lost; release pe_ready -> all 6 delivered in order.
REQ-037 pe_ready toggling 1010..., addr_valid always high, tile_len=16 -> pe_data stable while stalled, exactly 16 pops, one pe_last.
REQ-038 en=0 for 5 cycles after 3 accepts (tile_len=5) -> no mem_re during gap, 3 words deliverable, remaining 2 accepted after en=1, pe_last on 5th.
REQ-039 reset asserted 1 cycle after an accept with 2 words buffered -> next cycle pe_valid=0, busy=0, stale mem_rdata not delivered; new tile tile_len=2 works normally.
REQ-040 tile_len=0 -> treated as 1: single accept, pe_last with first word, then IDLE.
